// File: rtl/input_sweep_gen.sv
// Input sweep generator: applies {a,s,d} = 0..7 to a 3-in/2-out combinational
// block, holds each vector HOLD_CYCLES clocks, samples {x,y} at the end of each
// hold, packs the samples into a 16-bit word and compares it to EXPECTED.
module input_sweep_gen #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        x,
  input  logic        y,
  output logic        a,
  output logic        s,
  output logic        d,
  output logic [2:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_result;

  logic [15:0] w_result_next;
  logic        w_hold_end;

  assign w_hold_end = (r_cnt == LP_LAST);

  // Result word with the current {x,y} sample merged in; lets the final
  // compare include the sample taken on the same edge that enters DONE.
  always_comb begin
    w_result_next = r_result;
    w_result_next[{r_vec, 1'b0} +: 2] = {x, y};
  end

  // Sweep FSM: hold counter, vector index, sample packing and final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= SWEEP;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_result <= '0;
            r_vec    <= '0;
            r_cnt    <= '0;
          end
        end
        SWEEP: begin
          if (w_hold_end) begin
            r_result <= w_result_next;
            r_cnt    <= '0;
            if (r_vec == 3'd7) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_vec   <= '0;
              r_pass  <= (w_result_next == EXPECTED);
            end else begin
              r_vec <= r_vec + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a       = r_vec[2];
  assign s       = r_vec[1];
  assign d       = r_vec[0];
  assign vec_idx = r_vec;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign pass    = r_pass;

endmodule

// File: tb/tb_input_sweep_gen.sv
// Directed bench for input_sweep_gen with HOLD_CYCLES=4 and a full-adder-like
// model (x = parity, y = majority) whose packed result is 16'hD668.
module tb_input_sweep_gen;

  localparam int unsigned HOLD = 4;

  if (HOLD < 2 || HOLD > 255) begin : g_hold_range
    $fatal(1, "HOLD_CYCLES out of legal range 2..255");
  end

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic force_y0 = 1'b0;

  logic x0, y0, a0, s0, d0, busy0, done0, pass0;
  logic [2:0] vec0;
  logic [15:0] res0;

  logic x1, y1, a1, s1, d1, busy1, done1, pass1;
  logic [2:0] vec1;
  logic [15:0] res1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational lab-block models driven by each generator.
  assign x0 = a0 ^ s0 ^ d0;
  assign y0 = (force_y0 && vec0 == 3'd7) ? 1'b0 : ((a0 & s0) | (a0 & d0) | (s0 & d0));
  assign x1 = a1 ^ s1 ^ d1;
  assign y1 = (a1 & s1) | (a1 & d1) | (s1 & d1);

  input_sweep_gen #(.HOLD_CYCLES(HOLD), .EXPECTED(16'hD668)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x0), .y(y0),
    .a(a0), .s(s0), .d(d0), .vec_idx(vec0), .busy(busy0), .done(done0),
    .result(res0), .pass(pass0)
  );

  input_sweep_gen #(.HOLD_CYCLES(HOLD), .EXPECTED(16'hD669)) dut_bad (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x1), .y(y1),
    .a(a1), .s(s1), .d(d1), .vec_idx(vec1), .busy(busy1), .done(done1),
    .result(res1), .pass(pass1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #3;
    checks++;
    if ({a0, s0, d0, vec0, busy0, done0, res0, pass0} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state got asd=%b vec=%0d busy=%b done=%b res=%h pass=%b exp all zero",
               {a0, s0, d0}, vec0, busy0, done0, res0, pass0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy0, done0, vec0} !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b vec=%0d exp 0 0 0", busy0, done0, vec0);
    end
  endtask

  task automatic test_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      checks++;
      if (vec0 !== 3'(k / 4) || {a0, s0, d0} !== 3'(k / 4) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL sweep_step k=%0d got vec=%0d asd=%b busy=%b done=%b exp vec=%0d busy=1 done=0",
                 k, vec0, {a0, s0, d0}, busy0, done0, k / 4);
      end
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || res0 !== 16'hD668 || pass0 !== 1'b1 ||
        vec0 !== 3'd0 || {a0, s0, d0} !== 3'd0) begin
      errors++;
      $display("FAIL sweep_done got done=%b busy=%b res=%h pass=%b vec=%0d exp 1 0 d668 1 0",
               done0, busy0, res0, pass0, vec0);
    end
    checks++;
    if (done1 !== 1'b1 || res1 !== 16'hD668 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL wrong_expected got done=%b res=%h pass=%b exp 1 d668 0", done1, res1, pass1);
    end
    tick();
    tick();
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || res0 !== 16'hD668 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL sticky_idle got done=%b pass=%b res=%h busy=%b exp 1 1 d668 0",
               done0, pass0, res0, busy0);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || res0 !== 16'h0000) begin
      errors++;
      $display("FAIL accept_clears got done=%b busy=%b res=%h exp 0 1 0000", done0, busy0, res0);
    end
    for (int k = 1; k <= 31; k++) begin
      start = (k == 10);
      tick();
      checks++;
      if (vec0 !== 3'(k / 4) || done0 !== 1'b0) begin
        errors++;
        $display("FAIL busy_start k=%0d got vec=%0d done=%b exp vec=%0d done=0", k, vec0, done0, k / 4);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done0 !== 1'b1 || res0 !== 16'hD668 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_done got done=%b res=%h pass=%b exp 1 d668 1", done0, res0, pass0);
    end
    tick();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_start got busy=%b done=%b exp 0 1", busy0, done0);
    end
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 21; k++) tick();
    checks++;
    if (vec0 !== 3'd5) begin
      errors++;
      $display("FAIL pre_reset_vec got %0d exp 5", vec0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, s0, d0} !== 3'd0 || vec0 !== 3'd0 || busy0 !== 1'b0 || res0 !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got asd=%b vec=%0d busy=%b res=%h exp 0 0 0 0000",
               {a0, s0, d0}, vec0, busy0, res0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) tick();
    checks++;
    if (done0 !== 1'b1 || res0 !== 16'hD668 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_sweep got done=%b res=%h pass=%b exp 1 d668 1", done0, res0, pass0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    for (int k = 1; k <= 32; k++) tick();
    checks++;
    if (done0 !== 1'b1 || res0 !== 16'hD668) begin
      errors++;
      $display("FAIL b2b_first got done=%b res=%h exp 1 d668", done0, res0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got done=%b busy=%b exp 1 0", done0, busy0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || vec0 !== 3'd0 || res0 !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_accept got done=%b busy=%b vec=%0d res=%h exp 0 1 0 0000",
               done0, busy0, vec0, res0);
    end
    for (int k = 1; k <= 32; k++) tick();
    start = 1'b0;
    checks++;
    if (done0 !== 1'b1 || res0 !== 16'hD668 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got done=%b res=%h pass=%b exp 1 d668 1", done0, res0, pass0);
    end
    tick();
    tick();
  endtask

  task automatic test_force_y();
    force_y0 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) tick();
    checks++;
    if (done0 !== 1'b1 || res0 !== 16'h9668 || pass0 !== 1'b0) begin
      errors++;
      $display("FAIL force_y got done=%b res=%h pass=%b exp 1 9668 0", done0, res0, pass0);
    end
    force_y0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_force_y();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
